// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// HDR state exists only when UART_ARB_ID_PREFIX_EN is defined.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
`ifdef UART_ARB_ID_PREFIX_EN
    HDR,
`endif
    LOAD,
    WAIT_HI,
    WAIT_LO
  } arb_state_t;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  function automatic logic [7:0] hdr_byte(
    input logic [7:0] id
  );
    return HDR_BASE | id;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request
// bit found searching upward from last+1, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  always_comb begin : pick
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!found && req[j[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = j[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter feeding one UART transmitter.
// Define UART_ARB_ID_PREFIX_EN to prefix each message with 8'hA0|id.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  arb_state_t      state, state_n;
  logic            grant_valid_n;
  logic [ID_W-1:0] grant_id_n;
  logic [ID_W-1:0] last_grant, last_grant_n;
  logic            last_flag, last_flag_n;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[grant_id*8 +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      last_flag   <= 1'b0;
    end else begin
      state       <= state_n;
      grant_valid <= grant_valid_n;
      grant_id    <= grant_id_n;
      last_grant  <= last_grant_n;
      last_flag   <= last_flag_n;
    end
  end

  // last_flag remembers whether the byte in flight ends the message
  always_comb begin
    state_n       = state;
    grant_valid_n = grant_valid;
    grant_id_n    = grant_id;
    last_grant_n  = last_grant;
    last_flag_n   = last_flag;
    tx_start      = 1'b0;
    tx_data       = 8'h00;
    req_ready     = '0;
    unique case (state)
      IDLE: begin
        if (|req_valid) state_n = ARB;
      end
      ARB: begin
        if (pick_found) begin
          grant_valid_n = 1'b1;
          grant_id_n    = pick_idx;
`ifdef UART_ARB_ID_PREFIX_EN
          state_n       = HDR;
`else
          state_n       = LOAD;
`endif
        end else begin
          state_n = IDLE;
        end
      end
`ifdef UART_ARB_ID_PREFIX_EN
      HDR: begin
        if (!tx_busy) begin
          tx_start    = 1'b1;
          tx_data     = hdr_byte(8'(grant_id));
          last_flag_n = 1'b0;
          state_n     = WAIT_HI;
        end
      end
`endif
      LOAD: begin
        if (sel_valid && !tx_busy) begin
          tx_start            = 1'b1;
          tx_data             = sel_data;
          req_ready[grant_id] = 1'b1;
          last_flag_n         = sel_last;
          state_n             = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_flag) begin
            last_grant_n  = grant_id;
            grant_valid_n = 1'b0;
            state_n       = IDLE;
          end else begin
            state_n = LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ID_W, default 2, grant-index width, equal to clog2(NUM_REQ).
REQ-003 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester byte available.
REQ-006 SHALL have port req_last, input, NUM_REQ, per-requester flag marking the final byte of a message.
REQ-007 SHALL have port req_data, input, NUM_REQ*8, byte of requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_ready, output, NUM_REQ, one-hot single-cycle byte-accepted pulse.
REQ-009 SHALL have port tx_start, output, 1, launch pulse to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8, byte to the UART transmitter, valid while tx_start=1.
REQ-011 SHALL have port tx_busy, input, 1, UART transmitter busy flag.
REQ-012 SHALL have port grant_valid, output, 1, a requester currently owns the transmitter.
REQ-013 SHALL have port grant_id, output, ID_W, index of the owning requester.

Function
REQ-014 SHALL implement FSM states IDLE, ARB, HDR, LOAD, WAIT_HI, WAIT_LO.
REQ-015 IDLE->ARB when any req_valid=1; otherwise remain in IDLE.
REQ-016 ARB SHALL pick, in one cycle, the first valid requester searching round-robin from last_grant+1 (mod NUM_REQ), set grant_id and grant_valid=1, and go to HDR if the ID prefix is compiled in, otherwise to LOAD.
REQ-017 LOAD: if req_valid[grant_id]=1 and tx_busy=0, SHALL assert tx_start=1, tx_data=req_data[grant_id] and req_ready[grant_id]=1 for exactly one cycle, then go to WAIT_HI; otherwise hold in LOAD with grant kept.
REQ-018 WAIT_HI SHALL wait for tx_busy=1, then go to WAIT_LO; tx_start SHALL be 0 throughout.
REQ-019 WAIT_LO SHALL wait for tx_busy=0; if the launched byte had req_last=1, it SHALL update last_grant=grant_id, clear grant_valid and go to IDLE, otherwise return to LOAD.
REQ-020 Grant SHALL be held for a whole message (lock until req_last); other requests wait regardless of priority.
REQ-021 Requesters SHALL hold req_data/req_last stable while req_valid=1 until req_ready; the arbiter samples only in the req_ready cycle.
REQ-022 Minimum spacing between successive tx_start pulses SHALL be 3 cycles.
REQ-023 Round-robin SHALL be fair: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.

Reset
REQ-024 On rst: state=IDLE, tx_start=0, tx_data=8'h00, req_ready=0, grant_valid=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-025 Reset mid-message SHALL abandon the message; no byte is resent after reset release.

Configuration
REQ-026 Macro UART_ARB_ID_PREFIX_EN SHALL compile in state HDR: on entry, if tx_busy=0, it SHALL pulse tx_start with tx_data=8'hA0|grant_id (no req_ready), then pass through WAIT_HI/WAIT_LO and continue to LOAD.
REQ-027 Without UART_ARB_ID_PREFIX_EN, HDR SHALL not exist; ARB goes directly to LOAD and only requester bytes are transmitted.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the header constant 8'hA0 and the header-byte function.
REQ-029 The round-robin picker SHALL be a sub-module rr_picker (inputs: request vector, last grant; outputs: found, index), purely combinational.

Verification
REQ-030 Single requester 0 sends 8'h55 with last=1 -> one tx_start with tx_data=8'h55, req_ready[0] pulse, grant_valid low after tx_busy falls.
REQ-031 Requesters 1 and 3 valid together after reset -> requester 1's message sent in full before requester 3's; grant_id 1 then 3.
REQ-032 Requester 2 sends 3 bytes 8'h01,8'h02,8'h03 (last on 3rd) while requester 0 is valid -> the three bytes are contiguous on tx_data, then requester 0 is granted.
REQ-033 All four requesters continuously valid with single-byte messages -> grant order 0,1,2,3,0,1.
REQ-034 With UART_ARB_ID_PREFIX_EN, requester 3 sends 8'h7E -> tx_data sequence 8'hA3, 8'h7E.
REQ-035 Assert rst during WAIT_LO of byte 2 of a message -> all outputs at reset values next edge; after release, requester 0 is granted first.
